uart_rx_cfg: RTL and testbench
==============================

Name:
uart_rx_cfg

Overview:
Configurable UART receiver. Frame format is set at elaboration time: data width, parity mode and stop-bit count. Each bit is decided by a 3-sample majority vote at mid-bit. Reports parity error, framing error and line break per character. Sits between the board RX pin and the command/byte-stream consumer, and replaces the fixed 8n1 receiver in new builds.

Parameters:
CLKS_PER_BIT, 10, clk cycles per bit period; legal range >=4.
DATA_BITS, 8, data bits per frame, LSB first; legal range 5..9.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits; legal values 1 or 2.
SYNC_STAGES, 2, flops in the input synchroniser; legal range >=2.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_rx_data  in  1  asynchronous serial line, idle high
o_rx_valid  out  1  one-cycle pulse: character complete
o_rx_data  out  DATA_BITS  received character; held until next o_rx_valid
o_parity_err  out  1  parity mismatch; qualified by o_rx_valid
o_frame_err  out  1  any stop bit sampled low; qualified by o_rx_valid
o_break  out  1  break condition; qualified by o_rx_valid
o_rx_busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; synchroniser flops 1. Reset mid-frame aborts the frame with no valid pulse.
- All outputs are registered.
- Synchroniser: rx_s is the output of the last SYNC_STAGES stage.
- Definitions: H = CLKS_PER_BIT/2 (floor). N = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS.
- Bit counter cnt runs 0..CLKS_PER_BIT-1 and wraps to 0.
- Bit index k: 0 = start bit, then data, then parity, then stop bits.
- Majority vote: rx_s is sampled at cnt = H-1, H and H+1. The bit value is the majority of the three, decided at cnt = H+1.
- States: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- t0 is the cycle on which the FSM is in IDLE and rx_s==0. On t0: go to START, cnt<=1. Bit k is decided at t0 + k*CLKS_PER_BIT + H + 1.
- START: if the start bit decides 1, it was a glitch; return to IDLE with no output. Otherwise go to DATA.
- DATA: shift the decided bit into position k-1. After DATA_BITS bits, go to PARITY if PARITY!=0, else STOP.
- PARITY: check is XOR(data bits, parity bit) == 1 for odd, ==0 for even.
- STOP: every stop bit is decided. If any stop bit decides 0, frame_err=1.
- Completion: on the cycle after the final stop bit decision, i.e. t0 + (N-1)*CLKS_PER_BIT + H + 2:
  - o_rx_valid=1 for that one cycle;
  - o_rx_data, o_parity_err, o_frame_err and o_break are updated;
  - the FSM is already in IDLE or BRK_WAIT, so a start edge can be accepted within half a bit.
- Errors do not suppress data: the character is still delivered, with its error flags set.
- Break: every decided bit of the frame is 0, including parity and the first stop bit. Then o_break=1 and o_frame_err=1 with o_rx_valid, and the FSM enters BRK_WAIT.
- BRK_WAIT: stay until rx_s==1 for one full bit period (CLKS_PER_BIT consecutive cycles), then go to IDLE. No further valid pulses while the line is held low.
- Flags are 0 on every cycle where o_rx_valid=0.
- o_rx_busy falls on the completion cycle and stays high through BRK_WAIT.
- A falling edge during STOP of the previous frame is not seen until IDLE. Tolerated line drift is below +-(H-1) cycles per frame.

Test Plan:
- Defaults, send 0x55 then 0xA3 with a 1-stop gap -> two valid pulses, data 0x55 then 0xA3, all flags 0; valid at t0 + 9*10 + 7 = t0+97.
- PARITY=1, DATA_BITS=7, send 0x41 with correct parity bit (1) -> valid, parity_err 0. Resend with the parity bit flipped -> data 0x41, parity_err 1.
- STOP_BITS=2, send 0x3C with the second stop bit low -> valid, data 0x3C, frame_err 1, break 0.
- Low glitch of 3 cycles (CLKS_PER_BIT=10) -> no valid, busy returns to 0 by t0+7. A following valid frame 0x12 is received correctly.
- Line low for 20 bit times, then high 1 bit, then frame 0x7E -> exactly one valid with data 0, break 1, frame_err 1; busy stays high until the line has been high 10 cycles; then 0x7E is received with all flags 0.
- Assert rst for 1 cycle mid-DATA of 0xFF, then send 0x0F -> no valid for the aborted frame; valid with data 0x0F; outputs were 0 during reset.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: elaboration-time data width, parity and stop bits,
// 3-sample mid-bit majority vote, per-character parity/framing/break flags.
//   state    | meaning
//   S_IDLE   | line idle, waiting for rx_s low
//   S_START  | timing the start bit, glitch rejection
//   S_DATA   | deciding data bits, LSB first
//   S_PAR    | deciding the parity bit
//   S_STOP   | deciding stop bits, completion on the last one
//   S_BRK    | after a break, waiting for one full bit period of high line
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx_data,
  output logic                 o_rx_valid,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] C_S0   = CW'(H - 1);
  localparam logic [CW-1:0] C_S1   = CW'(H);
  localparam logic [CW-1:0] C_DEC  = CW'(H + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [3:0]    LAST_D = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_S = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;

  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic rx_s;
  logic [CW-1:0] cnt;
  logic [3:0] bit_idx;
  logic [DATA_BITS-1:0] data_sr;
  logic s0, s1, pbit, zero_acc, ferr_acc;
  logic decide, vote, t0, last_stop, brk_now, par_bad;
  logic valid_n, perr_n, ferr_n, brk_n;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx_data};
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

  assign t0     = (state == S_IDLE) && !rx_s;
  assign decide = (cnt == C_DEC) && (state inside {S_START, S_DATA, S_PAR, S_STOP});
  assign vote   = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign last_stop = (state == S_STOP) && decide && (bit_idx == LAST_S);
  // On the second stop bit zero_acc already includes the first one.
  assign brk_now   = zero_acc && ((bit_idx != 4'd0) || !vote);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (!rx_s) state_n = S_START;
      S_START: if (decide) state_n = vote ? S_IDLE : S_DATA;
      S_DATA:  if (decide && bit_idx == LAST_D) state_n = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (decide) state_n = S_STOP;
      S_STOP:  if (last_stop) state_n = brk_now ? S_BRK : S_IDLE;
      S_BRK:   if (rx_s && cnt == C_LAST) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    par_bad = 1'b0;
    if (PARITY == 1)      par_bad = ~(^data_sr ^ pbit);
    else if (PARITY == 2) par_bad = ^data_sr ^ pbit;
  end

  always_comb begin
    valid_n = last_stop;
    perr_n  = last_stop && par_bad;
    ferr_n  = last_stop && (ferr_acc || !vote);
    brk_n   = last_stop && brk_now;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      bit_idx  <= '0;
      data_sr  <= '0;
      s0       <= 1'b1;
      s1       <= 1'b1;
      pbit     <= 1'b0;
      zero_acc <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  cnt <= t0 ? C_ONE : '0;
        S_BRK:   cnt <= rx_s ? cnt + C_ONE : '0;
        default: begin
          if (state_n == S_BRK)  cnt <= '0;
          else if (cnt == C_LAST) cnt <= '0;
          else                    cnt <= cnt + C_ONE;
        end
      endcase
      if (cnt == C_S0) s0 <= rx_s;
      if (cnt == C_S1) s1 <= rx_s;
      if (state != state_n) bit_idx <= '0;
      else if (decide)      bit_idx <= bit_idx + 4'd1;
      for (int i = 0; i < DATA_BITS; i++)
        if (state == S_DATA && decide && bit_idx == 4'(i)) data_sr[i] <= vote;
      if (state == S_PAR && decide) pbit <= vote;
      if (t0) begin
        zero_acc <= 1'b1;
        ferr_acc <= 1'b0;
      end else if (decide) begin
        if (vote && (state inside {S_DATA, S_PAR} || (state == S_STOP && bit_idx == 4'd0)))
          zero_acc <= 1'b0;
        if (state == S_STOP && !vote) ferr_acc <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_rx_valid   <= 1'b0;
      o_rx_data    <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_rx_busy    <= 1'b0;
    end else begin
      o_rx_valid   <= valid_n;
      o_parity_err <= perr_n;
      o_frame_err  <= ferr_n;
      o_break      <= brk_n;
      o_rx_busy    <= (state_n != S_IDLE);
      if (valid_n) o_rx_data <= data_sr;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench: three receivers (8n1, 7o1, 8n2) on one clock, each with its own line.
module tb_uart_rx_cfg;
  localparam int C = 10;
  localparam int H = C / 2;

  typedef struct {
    logic [8:0] data;
    logic       pe, fe, bk;
    int         cyc;
  } exp_t;

  logic clk, rst;
  logic rx0, rx1, rx2;
  logic v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, bk0, bk1, bk2, b0, b1, b2;
  logic [7:0] d0, d2;
  logic [6:0] d1;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  exp_t sbq[3][$];

  uart_rx_cfg u0 (.clk(clk), .rst(rst), .i_rx_data(rx0), .o_rx_valid(v0), .o_rx_data(d0),
    .o_parity_err(pe0), .o_frame_err(fe0), .o_break(bk0), .o_rx_busy(b0));
  uart_rx_cfg #(.DATA_BITS(7), .PARITY(1)) u1 (.clk(clk), .rst(rst), .i_rx_data(rx1),
    .o_rx_valid(v1), .o_rx_data(d1), .o_parity_err(pe1), .o_frame_err(fe1), .o_break(bk1),
    .o_rx_busy(b1));
  uart_rx_cfg #(.STOP_BITS(2)) u2 (.clk(clk), .rst(rst), .i_rx_data(rx2), .o_rx_valid(v2),
    .o_rx_data(d2), .o_parity_err(pe2), .o_frame_err(fe2), .o_break(bk2), .o_rx_busy(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int nbits(int w);  return (w == 1) ? 7 : 8; endfunction
  function automatic int pmode(int w);  return (w == 1) ? 1 : 0; endfunction
  function automatic int nstops(int w); return (w == 2) ? 2 : 1; endfunction

  task automatic set_line(int w, logic v);
    case (w)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_bit(int w, logic v);
    set_line(w, v);
    idle(C);
  endtask

  task automatic send(int w, logic [8:0] d, bit flip, logic [1:0] stopv, bit push);
    int nb, pm, ns, n;
    logic x, pb;
    exp_t e;
    nb = nbits(w); pm = pmode(w); ns = nstops(w);
    n = 1 + nb + ((pm != 0) ? 1 : 0) + ns;
    x = 1'b0;
    for (int i = 0; i < nb; i++) x = x ^ d[i];
    pb = ((pm == 1) ? ~x : x) ^ flip;
    e.data = d;
    e.pe   = (pm != 0) && flip;
    e.fe   = !stopv[0] || (ns == 2 && !stopv[1]);
    e.bk   = 1'b0;
    e.cyc  = cyc + 2 + (n - 1) * C + H + 2;
    if (push) sbq[w].push_back(e);
    hold_bit(w, 1'b0);
    for (int i = 0; i < nb; i++) hold_bit(w, d[i]);
    if (pm != 0) hold_bit(w, pb);
    for (int i = 0; i < ns; i++) hold_bit(w, stopv[i]);
    set_line(w, 1'b1);
  endtask

  task automatic mon(int w, logic v, logic [8:0] d, logic pe, logic fe, logic bk);
    exp_t e;
    if (!v) begin
      chk("idle_flags", {29'd0, pe, fe, bk}, 32'd0);
    end else if (sbq[w].size() == 0) begin
      chk("unexpected_valid", 32'(w + 1), 32'd0);
    end else begin
      e = sbq[w].pop_front();
      chk("data", {23'd0, d}, {23'd0, e.data});
      chk("parity_err", {31'd0, pe}, {31'd0, e.pe});
      chk("frame_err", {31'd0, fe}, {31'd0, e.fe});
      chk("break", {31'd0, bk}, {31'd0, e.bk});
      chk("valid_cycle", cyc, e.cyc);
    end
  endtask

  always @(negedge clk) mon(0, v0, {1'b0, d0}, pe0, fe0, bk0);
  always @(negedge clk) mon(1, v1, {2'b0, d1}, pe1, fe1, bk1);
  always @(negedge clk) mon(2, v2, {1'b0, d2}, pe2, fe2, bk2);

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    exp_t e;
    rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    idle(3);
    chk("rst_out0", {v0, b0, pe0, fe0, bk0, d0}, 0);
    chk("rst_out1", {v1, b1, pe1, fe1, bk1, d1}, 0);
    chk("rst_out2", {v2, b2, pe2, fe2, bk2, d2}, 0);
    rst = 1'b0;
    idle(5);

    send(0, 9'h55, 0, 2'b11, 1);
    idle(C);
    send(0, 9'hA3, 0, 2'b11, 1);
    idle(20);

    send(1, 9'h41, 0, 2'b11, 1);
    idle(C);
    send(1, 9'h41, 1, 2'b11, 1);
    idle(20);

    send(2, 9'h3C, 0, 2'b01, 1);
    idle(30);

    // 3-cycle low glitch: start bit decides high at t0+6, idle again at t0+7
    c = cyc;
    set_line(0, 1'b0);
    idle(3);
    set_line(0, 1'b1);
    idle(2);
    chk("glitch_busy_hi", {31'd0, b0}, 32'd1);
    idle(4);
    chk("glitch_cycle", cyc, c + 9);
    chk("glitch_busy_lo", {31'd0, b0}, 32'd0);
    idle(20);
    send(0, 9'h12, 0, 2'b11, 1);
    idle(20);

    c = cyc;
    e.data = 9'h0; e.pe = 1'b0; e.fe = 1'b1; e.bk = 1'b1;
    e.cyc = c + 2 + 9 * C + H + 2;
    sbq[0].push_back(e);
    set_line(0, 1'b0);
    idle(20 * C);
    chk("brk_busy_low", {31'd0, b0}, 32'd1);
    hold_bit(0, 1'b1);
    fork
      send(0, 9'h7E, 0, 2'b11, 1);
      begin
        idle(1);
        chk("brk_busy_hold", {31'd0, b0}, 32'd1);
        idle(1);
        chk("brk_busy_release", {31'd0, b0}, 32'd0);
      end
    join
    idle(20);

    fork
      send(0, 9'hFF, 0, 2'b11, 0);
      begin
        idle(35);
        chk("pre_rst_busy", {31'd0, b0}, 32'd1);
        rst = 1'b1;
        idle(1);
        chk("mid_rst_out0", {v0, b0, pe0, fe0, bk0, d0}, 0);
        rst = 1'b0;
      end
    join
    idle(20);
    send(0, 9'h0F, 0, 2'b11, 1);
    idle(30);

    chk("sb_left0", sbq[0].size(), 0);
    chk("sb_left1", sbq[1].size(), 0);
    chk("sb_left2", sbq[2].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
